// File: rtl/blast_sequencer_pkg.sv
// rtl/blast_sequencer_pkg.sv - shared tile codes, grid size and FSM/direction types for blast_sequencer
package blast_sequencer_pkg;

  localparam int STAGE_GRID = 11;

  localparam logic [3:0] TILE_EMPTY   = 4'd0;
  localparam logic [3:0] TILE_WALL    = 4'd1;
  localparam logic [3:0] TILE_BREAK   = 4'd2;
  localparam logic [3:0] TILE_PWR_MIN = 4'd3;

  localparam logic [1:0] MAX_ARM_LEN = 2'd3;

  typedef enum logic [1:0] {DIR_PX, DIR_PY, DIR_NX, DIR_NY} dir_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT_RD, ST_INIT_WR, ST_ARB, ST_ARM_RD, ST_ARM_EV, ST_DONE
  } state_t;

endpackage

// File: rtl/blast_sequencer_if.sv
// rtl/blast_sequencer_if.sv - stage/init RAM port bundle between blast_sequencer and the tile RAMs
interface blast_sequencer_if;

  logic [6:0] st_addr;
  logic       st_wr_en;
  logic [3:0] st_wr_data;
  logic [3:0] st_rd_data;
  logic [3:0] init_rd_data;

  modport master (
    output st_addr, st_wr_en, st_wr_data,
    input  st_rd_data, init_rd_data
  );

  modport slave (
    input  st_addr, st_wr_en, st_wr_data,
    output st_rd_data, init_rd_data
  );

endinterface

// File: rtl/blast_sequencer_rr_arbiter.sv
// rtl/blast_sequencer_rr_arbiter.sv - rr_arbiter: one-hot grant to the first requester at or after ptr
module rr_arbiter #(
  parameter  int N  = 6,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/blast_sequencer.sv
// rtl/blast_sequencer.sv - serialises bomb blasts and the stage-load pass onto the stage RAM.
// POWERUP_REVEAL_EN: breakable tiles are replaced by the hidden init power-up instead of empty.
module blast_sequencer
  import blast_sequencer_pkg::*;
#(
  parameter int NUM_REQ = 6,
  parameter int GRID    = STAGE_GRID
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stage_init,
  input  logic [NUM_REQ-1:0]   det_req,
  input  logic [4*NUM_REQ-1:0] det_tx,
  input  logic [4*NUM_REQ-1:0] det_ty,
  input  logic [2*NUM_REQ-1:0] det_radius,
  output logic [NUM_REQ-1:0]   det_ack,
  blast_sequencer_if.master    ram,
  output logic                 busy,
  output logic                 blast_done,
  output logic [3:0]           cleared_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [6:0]    init_addr_q, init_addr_d;
  logic [3:0]    bx_q, bx_d, by_q, by_d;
  logic [1:0]    len_q, len_d, dist_q, dist_d;
  dir_t          dir_q, dir_d;
  logic [3:0]    cnt_q, cnt_d, cleared_q, cleared_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_valid;
  logic [1:0]         code;

  logic [4:0] cx, cy, d5, tx5, ty5;
  logic       in_range;
  logic [6:0] tgt_addr;
  logic [3:0] repl;
  logic       end_arm;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (det_req),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign code = det_radius[2*gnt_idx +: 2];

  // Unsigned 5-bit maths: bit 4 set means the target fell below 0 (or overflowed).
  always_comb begin
    cx  = {1'b0, bx_q};
    cy  = {1'b0, by_q};
    d5  = {3'b000, dist_q};
    tx5 = cx;
    ty5 = cy;
    case (dir_q)
      DIR_PX:  tx5 = cx + d5;
      DIR_PY:  ty5 = cy + d5;
      DIR_NX:  tx5 = cx - d5;
      default: ty5 = cy - d5;
    endcase
    in_range = !tx5[4] && !ty5[4] && (int'(tx5[3:0]) < GRID) && (int'(ty5[3:0]) < GRID);
    tgt_addr = 7'(ty5[3:0]) * 7'(GRID) + 7'(tx5[3:0]);
  end

  always_comb begin
`ifdef POWERUP_REVEAL_EN
    repl = (ram.init_rd_data >= TILE_PWR_MIN) ? ram.init_rd_data : TILE_EMPTY;
`else
    repl = TILE_EMPTY;
`endif
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    init_addr_d    = init_addr_q;
    bx_d           = bx_q;
    by_d           = by_q;
    len_d          = len_q;
    dist_d         = dist_q;
    dir_d          = dir_q;
    cnt_d          = cnt_q;
    cleared_d      = cleared_q;
    end_arm        = 1'b0;
    ram.st_addr    = '0;
    ram.st_wr_en   = 1'b0;
    ram.st_wr_data = '0;
    det_ack        = '0;
    blast_done     = 1'b0;

    case (state_q)
      ST_IDLE: if (|det_req) state_d = ST_ARB;
      ST_INIT_RD: begin
        ram.st_addr = init_addr_q;
        state_d     = ST_INIT_WR;
      end
      ST_INIT_WR: begin
        ram.st_addr    = init_addr_q;
        ram.st_wr_en   = 1'b1;
        ram.st_wr_data = (ram.init_rd_data < TILE_BREAK) ? ram.init_rd_data : TILE_BREAK;
        if (init_addr_q == 7'(GRID*GRID - 1)) begin
          state_d = ST_IDLE;
        end else begin
          init_addr_d = init_addr_q + 7'd1;
          state_d     = ST_INIT_RD;
        end
      end
      ST_ARB: begin
        if (gnt_valid) begin
          det_ack = gnt;
          bx_d    = det_tx[4*gnt_idx +: 4];
          by_d    = det_ty[4*gnt_idx +: 4];
          len_d   = (code == MAX_ARM_LEN) ? MAX_ARM_LEN : code + 2'd1;
          ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          dir_d   = DIR_PX;
          dist_d  = 2'd1;
          cnt_d   = '0;
          state_d = ST_ARM_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM_RD: begin
        if (in_range) begin
          ram.st_addr = tgt_addr;
          state_d     = ST_ARM_EV;
        end else begin
          end_arm = 1'b1;
        end
      end
      ST_ARM_EV: begin
        ram.st_addr = tgt_addr;
        if (ram.st_rd_data == TILE_EMPTY) begin
          if (dist_q == len_q) begin
            end_arm = 1'b1;
          end else begin
            dist_d  = dist_q + 2'd1;
            state_d = ST_ARM_RD;
          end
        end else if (ram.st_rd_data == TILE_WALL) begin
          end_arm = 1'b1;
        end else begin
          ram.st_wr_en   = 1'b1;
          ram.st_wr_data = (ram.st_rd_data == TILE_BREAK) ? repl : TILE_EMPTY;
          cnt_d          = cnt_q + 4'd1;
          end_arm        = 1'b1;
        end
      end
      ST_DONE: begin
        blast_done = 1'b1;
        state_d    = (|det_req) ? ST_ARB : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_arm) begin
      if (dir_q == DIR_NY) begin
        state_d   = ST_DONE;
        cleared_d = cnt_d;
      end else begin
        dir_d   = dir_t'(dir_q + 2'd1);
        dist_d  = 2'd1;
        state_d = ST_ARM_RD;
      end
    end

    // A load request overrides everything, including a blast's pending write and grant.
    if (stage_init) begin
      state_d      = ST_INIT_RD;
      init_addr_d  = '0;
      cleared_d    = cleared_q;
      det_ack      = '0;
      ram.st_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      init_addr_q <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      len_q       <= '0;
      dist_q      <= '0;
      dir_q       <= DIR_PX;
      cnt_q       <= '0;
      cleared_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_addr_q <= init_addr_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      len_q       <= len_d;
      dist_q      <= dist_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      cleared_q   <= cleared_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign cleared_cnt = cleared_q;

endmodule

// File: tb/tb_blast_sequencer.sv
// tb/tb_blast_sequencer.sv - self-checking bench for blast_sequencer with a behavioural stage model
module tb_blast_sequencer;
  import blast_sequencer_pkg::*;

  localparam int N = 6;
  localparam int G = 11;
  localparam int CELLS = G*G;

  logic           clk = 1'b0;
  logic           reset;
  logic           stage_init;
  logic [N-1:0]   det_req;
  logic [4*N-1:0] det_tx, det_ty;
  logic [2*N-1:0] det_radius;
  logic [N-1:0]   det_ack;
  logic           busy, blast_done;
  logic [3:0]     cleared_cnt;

  blast_sequencer_if ram ();

  blast_sequencer #(.NUM_REQ(N), .GRID(G)) dut (
    .clk(clk), .reset(reset), .stage_init(stage_init),
    .det_req(det_req), .det_tx(det_tx), .det_ty(det_ty), .det_radius(det_radius),
    .det_ack(det_ack), .ram(ram), .busy(busy), .blast_done(blast_done),
    .cleared_cnt(cleared_cnt)
  );

  always #10 clk = ~clk;

  logic [3:0] stage    [CELLS];
  logic [3:0] preset   [CELLS];
  logic [3:0] init_mem [CELLS];
  logic [3:0] exp_stage[CELLS];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < CELLS; i++) stage[i] <= preset[i];
    end else if (ram.st_wr_en) begin
      stage[ram.st_addr] <= ram.st_wr_data;
    end
    ram.st_rd_data   <= stage[ram.st_addr];
    ram.init_rd_data <= init_mem[ram.st_addr];
  end

  int cyc = 0, wr_cnt = 0, done_cnt = 0, ack_cnt = 0, wall_wr = 0, centre_wr = 0;
  int centre_addr = 0;
  logic blast_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram.st_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (blast_active && stage[ram.st_addr] == TILE_WALL) wall_wr <= wall_wr + 1;
      if (blast_active && int'(ram.st_addr) == centre_addr) centre_wr <= centre_wr + 1;
    end
    if (blast_done) done_cnt <= done_cnt + 1;
    if (det_ack != '0) ack_cnt <= ack_cnt + 1;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_stage();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic int stage_mismatches();
    int m = 0;
    for (int i = 0; i < CELLS; i++) if (stage[i] !== exp_stage[i]) m++;
    return m;
  endfunction

  // Reference blast: walk each arm on the expected map using the game rules directly.
  function automatic int model_blast(input int x, input int y, input int code);
    int dx[4] = '{1, 0, -1, 0};
    int dy[4] = '{0, 1, 0, -1};
    int len = (code == 3) ? 3 : code + 1;
    int cnt = 0;
    for (int a = 0; a < 4; a++) begin
      for (int d = 1; d <= len; d++) begin
        int px = x + dx[a]*d;
        int py = y + dy[a]*d;
        int t;
        if (px < 0 || py < 0 || px >= G || py >= G) break;
        t = int'(exp_stage[py*G + px]);
        if (t == 0) continue;
        if (t == 1) break;
        if (t == 2) begin
`ifdef POWERUP_REVEAL_EN
          exp_stage[py*G + px] = (init_mem[py*G + px] >= 4'd3) ? init_mem[py*G + px] : 4'd0;
`else
          exp_stage[py*G + px] = 4'd0;
`endif
        end else begin
          exp_stage[py*G + px] = 4'd0;
        end
        cnt++;
        break;
      end
    end
    return cnt;
  endfunction

  task automatic wait_ack(input string tag, output logic [N-1:0] a);
    int n = 0;
    a = '0;
    while (n < 50) begin
      @(negedge clk);
      if (det_ack != '0) begin a = det_ack; break; end
      n++;
    end
    check({tag, "_ack_seen"}, 32'(a != '0), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int at);
    int n = 0;
    at = -1;
    while (n < 300) begin
      @(negedge clk);
      if (blast_done) begin at = cyc; break; end
      n++;
    end
    check({tag, "_done_seen"}, 32'(at >= 0), 32'd1);
  endtask

  task automatic do_blast(input string tag, input int k, input int x, input int y,
                          input int code, input int exp_lat);
    logic [N-1:0] a;
    int exp_cnt, t0, td, w0, d0, k0, wl0, c0;
    for (int i = 0; i < CELLS; i++) exp_stage[i] = preset[i];
    exp_cnt = model_blast(x, y, code);
    det_tx[4*k +: 4]     = 4'(x);
    det_ty[4*k +: 4]     = 4'(y);
    det_radius[2*k +: 2] = 2'(code);
    centre_addr  = y*G + x;
    blast_active = 1'b1;
    w0 = wr_cnt; d0 = done_cnt; k0 = ack_cnt; wl0 = wall_wr; c0 = centre_wr;
    det_req[k] = 1'b1;
    wait_ack(tag, a);
    t0 = cyc;
    check({tag, "_ack_onehot"}, 32'(a), 32'(1 << k));
    @(posedge clk); #1 det_req[k] = 1'b0;
    wait_done(tag, td);
    check({tag, "_cleared"}, 32'(cleared_cnt), 32'(exp_cnt));
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(td - t0), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_ack_once"}, 32'(ack_cnt - k0), 32'd1);
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_cnt));
    check({tag, "_wall_wr"}, 32'(wall_wr - wl0), 32'd0);
    check({tag, "_centre_wr"}, 32'(centre_wr - c0), 32'd0);
    check({tag, "_stage"}, 32'(stage_mismatches()), 32'd0);
    blast_active = 1'b0;
  endtask

  task automatic init_pass(output int n, output int wd);
    int w0;
    @(posedge clk); #1 stage_init = 1'b1;
    @(posedge clk); #1 stage_init = 1'b0;
    w0 = wr_cnt;
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    wd = wr_cnt - w0;
    for (int i = 0; i < CELLS; i++) exp_stage[i] = (init_mem[i] < 4'd2) ? init_mem[i] : 4'd2;
  endtask

  task automatic fill_empty();
    for (int i = 0; i < CELLS; i++) preset[i] = TILE_EMPTY;
  endtask

  initial begin
    logic [N-1:0] a;
    int n, wd, td, d0;

    reset = 1'b1; stage_init = 1'b0; det_req = '0;
    det_tx = '0; det_ty = '0; det_radius = '0;
    for (int i = 0; i < CELLS; i++) begin preset[i] = 4'hf; init_mem[i] = 4'($urandom_range(0, 15)); end
    init_mem[5] = 4'd7; init_mem[6] = 4'd1;
    load_stage();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(blast_done), 32'd0);
    check("rst_ack", 32'(det_ack), 32'd0);
    check("rst_wr_en", 32'(ram.st_wr_en), 32'd0);
    check("rst_addr", 32'(ram.st_addr), 32'd0);
    check("rst_wr_data", 32'(ram.st_wr_data), 32'd0);
    check("rst_cleared", 32'(cleared_cnt), 32'd0);
    #1 reset = 1'b0;

    init_pass(n, wd);
    check("init_cycles", 32'(n), 32'd242);
    check("init_writes", 32'(wd), 32'd121);
    check("init_cell5", 32'(stage[5]), 32'd2);
    check("init_cell6", 32'(stage[6]), 32'd1);
    check("init_stage", 32'(stage_mismatches()), 32'd0);

    fill_empty();
    preset[25] = TILE_BREAK; preset[35] = TILE_BREAK; preset[23] = TILE_BREAK; preset[13] = TILE_BREAK;
    init_mem[25] = 4'd9; init_mem[35] = 4'd0; init_mem[23] = 4'd1; init_mem[13] = 4'd2;
    load_stage();
    do_blast("r0_cross", 0, 2, 2, 0, -1);
`ifdef POWERUP_REVEAL_EN
    check("reveal_3_2", 32'(stage[25]), 32'd9);
`else
    check("reveal_3_2", 32'(stage[25]), 32'd0);
`endif

    fill_empty();
    preset[1] = TILE_WALL; preset[11] = TILE_WALL;
    load_stage();
    do_blast("corner", 2, 0, 0, 2, -1);
    check("corner_wall", 32'(stage[1]), 32'd1);

    fill_empty();
    load_stage();
    do_blast("open_r3", 3, 5, 5, 2, 25);

    do_reset();
    fill_empty();
    load_stage();
    det_tx = {6{4'd5}}; det_ty = {6{4'd5}}; det_radius = {6{2'd1}};
    det_req = 6'b010010;
    wait_ack("rr1", a);
    check("rr_first", 32'(a), 32'b000010);
    @(posedge clk); #1 det_req[1] = 1'b0;
    wait_done("rr1", td);
    @(negedge clk);
    check("rr_second", 32'(det_ack), 32'b010000);
    @(posedge clk); #1 det_req[4] = 1'b0;
    wait_done("rr2", td);
    @(posedge clk); #1 det_req = 6'b100001;
    wait_ack("rr3", a);
    check("rr_ptr5", 32'(a), 32'b100000);
    @(posedge clk); #1 det_req[5] = 1'b0;
    wait_done("rr3", td);
    @(negedge clk);
    check("rr_wrap", 32'(det_ack), 32'b000001);
    @(posedge clk); #1 det_req[0] = 1'b0;
    wait_done("rr4", td);

    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < CELLS; i++) begin
        int r = $urandom_range(0, 9);
        preset[i] = (r < 5) ? TILE_EMPTY : (r == 5) ? TILE_WALL : (r < 8) ? TILE_BREAK
                    : 4'($urandom_range(3, 15));
        init_mem[i] = 4'($urandom_range(0, 15));
      end
      load_stage();
      do_blast("rand", $urandom_range(0, N-1), $urandom_range(0, G-1),
               $urandom_range(0, G-1), $urandom_range(0, 2), -1);
    end

    fill_empty();
    preset[8*G + 5] = TILE_BREAK; preset[5*G + 8] = TILE_BREAK;
    preset[5*G + 2] = TILE_BREAK; preset[2*G + 5] = TILE_BREAK;
    load_stage();
    det_tx[4*2 +: 4] = 4'd5; det_ty[4*2 +: 4] = 4'd5; det_radius[2*2 +: 2] = 2'd2;
    d0 = done_cnt;
    td = int'(cleared_cnt);
    det_req[2] = 1'b1;
    wait_ack("abort", a);
    @(posedge clk); #1 det_req[2] = 1'b0;
    repeat (3) @(posedge clk);
    init_pass(n, wd);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_cycles", 32'(n), 32'd242);
    check("abort_writes", 32'(wd), 32'd121);
    check("abort_cleared_held", 32'(cleared_cnt), 32'(td));
    check("abort_stage", 32'(stage_mismatches()), 32'd0);

    for (int i = 0; i < CELLS; i++) preset[i] = 4'hf;
    load_stage();
    @(posedge clk); #1 stage_init = 1'b1;
    @(posedge clk); #1 stage_init = 1'b0;
    repeat (60) @(posedge clk);
    init_pass(n, wd);
    check("restart_cycles", 32'(n), 32'd242);
    check("restart_writes", 32'(wd), 32'd121);
    check("restart_stage", 32'(stage_mismatches()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
